// File: rtl/alu_regfile.sv
// Operand register file and C/Z/N flag register for the 8-bit datapath; optional write bypass under ALU_REGFILE_BYPASS_EN.
// Latency: reads are combinational, writes and flag updates take effect one clk edge later.
// Backpressure: none; every cycle is an independent fetch/write-back slot.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int REG_N  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              carry_in,
    input  logic              flag_en,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n
);

    logic [DATA_W-1:0] regs [REG_N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end
            // Flags follow the result bus, so compare-style ops update them without a write.
            if (flag_en) begin
                flag_c <= carry_in;
                flag_z <= (wr_data == '0);
                flag_n <= wr_data[DATA_W-1];
            end
        end
    end

`ifdef ALU_REGFILE_BYPASS_EN
    logic byp_a;
    logic byp_b;

    assign byp_a     = wr_en && !rst && (rd_addr_a == wr_addr);
    assign byp_b     = wr_en && !rst && (rd_addr_b == wr_addr);
    assign rd_data_a = byp_a ? wr_data : regs[rd_addr_a];
    assign rd_data_b = byp_b ? wr_data : regs[rd_addr_b];
`else
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
`endif

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: directed vector table, read-during-write sequences, random run vs. model.
module tb_alu_regfile;

`ifdef ALU_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] rd_addr_a;
    logic [1:0] rd_addr_b;
    logic [7:0] rd_data_a;
    logic [7:0] rd_data_b;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       carry_in;
    logic       flag_en;
    logic       flag_c;
    logic       flag_z;
    logic       flag_n;

    alu_regfile #(.DATA_W(8), .REG_N(4), .ADDR_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .carry_in  (carry_in),
        .flag_en   (flag_en),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       we;
        logic [1:0] wa;
        logic [7:0] wd;
        logic       ci;
        logic       fe;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ec;
        logic       ez;
        logic       en;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Reference state: plain array of register contents plus three flag bits.
    logic [7:0] m [4];
    logic       mc, mz, mn;

    vec_t vecs [19];

    function automatic vec_t mk(input logic r, input logic we, input logic [1:0] wa,
                                input logic [7:0] wd, input logic ci, input logic fe,
                                input logic [1:0] ra, input logic [1:0] rb,
                                input logic [7:0] ea, input logic [7:0] eb,
                                input logic ec, input logic ez, input logic en);
        vec_t v;
        v.r = r; v.we = we; v.wa = wa; v.wd = wd; v.ci = ci; v.fe = fe;
        v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.ec = ec; v.ez = ez; v.en = en;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Drive one slot, check reads and flags mid-cycle, then advance the model across the edge.
    task automatic cycle(input logic r, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic ci, input logic fe, input logic [1:0] ra, input logic [1:0] rb,
                         input logic [7:0] ea, input logic [7:0] eb,
                         input logic ec, input logic ez, input logic en, input string tag);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        carry_in = ci; flag_en = fe; rd_addr_a = ra; rd_addr_b = rb;
        @(negedge clk);
        check({tag, "_rd_a"}, rd_data_a, ea);
        check({tag, "_rd_b"}, rd_data_b, eb);
        check({tag, "_flag_c"}, {7'd0, flag_c}, {7'd0, ec});
        check({tag, "_flag_z"}, {7'd0, flag_z}, {7'd0, ez});
        check({tag, "_flag_n"}, {7'd0, flag_n}, {7'd0, en});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) m[i] = 8'h00;
            mc = 1'b0; mz = 1'b0; mn = 1'b0;
        end else begin
            if (we) m[wa] = wd;
            if (fe) begin
                mc = ci;
                mz = (wd == 8'h00);
                mn = (wd >= 8'h80);
            end
        end
        #1;
    endtask

    task automatic mcycle(input logic r, input logic we, input logic [1:0] wa, input logic [7:0] wd,
                          input logic ci, input logic fe, input logic [1:0] ra, input logic [1:0] rb,
                          input string tag);
        logic [7:0] ea, eb;
        ea = (BYP && we && !r && ra == wa) ? wd : m[ra];
        eb = (BYP && we && !r && rb == wa) ? wd : m[rb];
        cycle(r, we, wa, wd, ci, fe, ra, rb, ea, eb, mc, mz, mn, tag);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00;
        carry_in = 1'b0; flag_en = 1'b0; rd_addr_a = 2'd0; rd_addr_b = 2'd0;
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        mc = 1'b0; mz = 1'b0; mn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        //                r  we wa    wd    ci fe ra    rb    ea     eb     c  z  n
        vecs[0]  = mk(0, 1, 2'd0, 8'hAA, 0, 0, 2'd2, 2'd3, 8'h00, 8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 1, 2'd1, 8'hAA, 0, 0, 2'd0, 2'd2, 8'hAA, 8'h00, 0, 0, 0);
        vecs[2]  = mk(0, 1, 2'd2, 8'hAA, 0, 0, 2'd1, 2'd0, 8'hAA, 8'hAA, 0, 0, 0);
        vecs[3]  = mk(0, 1, 2'd3, 8'hAA, 0, 0, 2'd2, 2'd1, 8'hAA, 8'hAA, 0, 0, 0);
        vecs[4]  = mk(1, 0, 2'd0, 8'h00, 0, 0, 2'd3, 2'd0, 8'hAA, 8'hAA, 0, 0, 0);
        vecs[5]  = mk(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 2'd1, 8'h00, 8'h00, 0, 0, 0);
        vecs[6]  = mk(0, 0, 2'd0, 8'h00, 0, 0, 2'd2, 2'd3, 8'h00, 8'h00, 0, 0, 0);
        vecs[7]  = mk(0, 1, 2'd1, 8'hF8, 0, 0, 2'd0, 2'd3, 8'h00, 8'h00, 0, 0, 0);
        vecs[8]  = mk(0, 1, 2'd2, 8'h1F, 0, 0, 2'd1, 2'd3, 8'hF8, 8'h00, 0, 0, 0);
        vecs[9]  = mk(0, 0, 2'd0, 8'h00, 0, 0, 2'd1, 2'd2, 8'hF8, 8'h1F, 0, 0, 0);
        vecs[10] = mk(0, 1, 2'd3, 8'h17, 1, 1, 2'd1, 2'd2, 8'hF8, 8'h1F, 0, 0, 0);
        vecs[11] = mk(0, 0, 2'd3, 8'h00, 0, 1, 2'd3, 2'd3, 8'h17, 8'h17, 1, 0, 0);
        vecs[12] = mk(0, 0, 2'd0, 8'h00, 0, 0, 2'd3, 2'd0, 8'h17, 8'h00, 0, 1, 0);
        vecs[13] = mk(0, 0, 2'd0, 8'hE0, 0, 1, 2'd1, 2'd2, 8'hF8, 8'h1F, 0, 1, 0);
        vecs[14] = mk(0, 0, 2'd0, 8'h00, 1, 0, 2'd1, 2'd2, 8'hF8, 8'h1F, 0, 0, 1);
        vecs[15] = mk(0, 0, 2'd0, 8'h7F, 1, 0, 2'd1, 2'd2, 8'hF8, 8'h1F, 0, 0, 1);
        vecs[16] = mk(0, 0, 2'd0, 8'h80, 0, 0, 2'd1, 2'd2, 8'hF8, 8'h1F, 0, 0, 1);
        vecs[17] = mk(1, 1, 2'd0, 8'h55, 1, 1, 2'd0, 2'd3, 8'h00, 8'h17, 0, 0, 1);
        vecs[18] = mk(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 2'd3, 8'h00, 8'h00, 0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].r, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ci, vecs[i].fe,
                  vecs[i].ra, vecs[i].rb, vecs[i].ea, vecs[i].eb,
                  vecs[i].ec, vecs[i].ez, vecs[i].en, $sformatf("vec%0d", i));
        end

        // Read-during-write on each port, and reset suppressing the bypass path.
        cycle(0, 1, 2'd0, 8'h11, 0, 0, 2'd1, 2'd2, 8'h00, 8'h00, 0, 0, 0, "rdw_setup");
        cycle(0, 1, 2'd0, 8'h22, 0, 0, 2'd0, 2'd1, BYP ? 8'h22 : 8'h11, 8'h00, 0, 0, 0, "rdw_a");
        cycle(0, 1, 2'd1, 8'h33, 0, 0, 2'd0, 2'd1, 8'h22, BYP ? 8'h33 : 8'h00, 0, 0, 0, "rdw_b");
        cycle(0, 0, 2'd0, 8'h00, 0, 0, 2'd0, 2'd1, 8'h22, 8'h33, 0, 0, 0, "rdw_after");
        cycle(0, 1, 2'd2, 8'h66, 0, 0, 2'd2, 2'd2, BYP ? 8'h66 : 8'h00, BYP ? 8'h66 : 8'h00, 0, 0, 0, "rdw_ab");
        cycle(1, 1, 2'd2, 8'h44, 0, 0, 2'd2, 2'd0, 8'h66, 8'h22, 0, 0, 0, "rst_nobyp");
        cycle(0, 0, 2'd0, 8'h00, 0, 0, 2'd2, 2'd0, 8'h00, 8'h00, 0, 0, 0, "rst_after");

        for (int i = 0; i < 400; i++) begin
            mcycle($urandom_range(31) == 0, 1'($urandom_range(1)), 2'($urandom_range(3)),
                   ($urandom_range(5) == 0) ? 8'h00 : 8'($urandom_range(255)),
                   1'($urandom_range(1)), 1'($urandom_range(1)),
                   2'($urandom_range(3)), 2'($urandom_range(3)), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
